// File: rtl/filter_pkg.sv
// ============================================================================
// Module : filter_pkg
// Brief  : Shared types for the filter frame controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package filter_pkg;

    typedef enum logic [1:0] {
        MODE_DEBAYER = 2'b00,
        MODE_BRIGHT  = 2'b01,
        MODE_RSVD2   = 2'b10,
        MODE_RSVD3   = 2'b11
    } filter_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } frame_state_t;

    localparam int c_PIX_W  = 32;
    localparam int c_BETA_W = 8;

    // Both reserved encodings have the upper bit set.
    function automatic logic mode_is_reserved(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/filter_out_stage.sv
// ============================================================================
// Module : filter_out_stage
// Brief  : One-entry valid/ready output register carrying data and last flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module filter_out_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic              r_last;
    logic [DATA_W-1:0] r_data;

    // A load may coincide with a pop; the caller only loads when the slot frees.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/filter_frame_ctrl.sv
// ============================================================================
// Module : filter_frame_ctrl
// Brief  : Frame sequencer for the filter datapath: latches config at start,
//          counts words and streams registered filter results downstream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module filter_frame_ctrl
    import filter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          cfg_mode,
    input  logic [c_BETA_W-1:0] cfg_beta,
    input  logic [CNT_W-1:0]    cfg_words,
    input  logic                in_valid,
    input  logic [c_PIX_W-1:0]  in_data,
    output logic                in_ready,
    output logic [c_PIX_W-1:0]  filt_in,
    output logic [1:0]          filt_mode,
    output logic [c_BETA_W-1:0] filt_beta,
    input  logic [c_PIX_W-1:0]  filt_result,
    output logic                out_valid,
    output logic [c_PIX_W-1:0]  out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                err_mode
);

    frame_state_t        r_state;
    frame_state_t        w_state_nxt;
    filter_mode_t        r_mode;
    logic [c_BETA_W-1:0] r_beta;
    logic [CNT_W-1:0]    r_words;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err_mode;

    logic                w_in_ready;
    logic                w_in_xfer;
    logic                w_last_in;
    logic                w_start_ok;
    logic                w_out_valid;
    logic                w_out_last;

    assign w_last_in = (r_cnt == r_words - CNT_W'(1));
    assign w_in_xfer = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    if (mode_is_reserved(cfg_mode) || (cfg_words == '0)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                w_in_ready = !w_out_valid || out_ready;
                if (in_valid && w_in_ready && w_last_in) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_valid && out_ready && w_out_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            w_state_nxt = IDLE;
            w_start_ok  = 1'b0;
            w_in_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_words    <= '0;
            r_mode     <= MODE_DEBAYER;
            r_beta     <= '0;
            r_err_mode <= 1'b0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (w_start_ok) begin
            r_cnt      <= '0;
            r_words    <= cfg_words;
            r_mode     <= filter_mode_t'(cfg_mode);
            r_beta     <= cfg_beta;
            r_err_mode <= mode_is_reserved(cfg_mode);
        end else if (w_in_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    filter_out_stage #(
        .DATA_W (c_PIX_W)
    ) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .i_flush (abort),
        .i_load  (w_in_xfer),
        .i_data  (filt_result),
        .i_last  (w_last_in),
        .i_ready (out_ready),
        .o_valid (w_out_valid),
        .o_data  (out_data),
        .o_last  (w_out_last)
    );

    assign in_ready  = w_in_ready;
    assign filt_in   = in_data;
    assign filt_mode = r_mode;
    assign filt_beta = r_beta;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_last;
    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign err_mode  = r_err_mode;

endmodule

`default_nettype wire

// File: tb/tb_filter_frame_ctrl.sv
// ============================================================================
// Module : tb_filter_frame_ctrl
// Brief  : Randomized frame bench for filter_frame_ctrl with a word-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_filter_frame_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       cfg_mode = '0;
    logic [7:0]       cfg_beta = '0;
    logic [CNT_W-1:0] cfg_words = '0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready;
    logic [31:0]      filt_in;
    logic [1:0]       filt_mode;
    logic [7:0]       filt_beta;
    logic [31:0]      filt_result;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             err_mode;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference view of the frame
    logic        m_active;
    logic        m_done;
    logic        m_err;
    logic [1:0]  m_mode;
    logic [7:0]  m_beta;
    int          m_words;
    int          m_nin;
    int          m_nout;
    logic [31:0] m_q[$];

    always #5 clk = ~clk;

    // Stand-in filter: any invertible mix of the word with the latched config.
    assign filt_result = filt_in ^ {filt_mode, 22'h0, filt_beta};

    filter_frame_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_beta(cfg_beta), .cfg_words(cfg_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .filt_in(filt_in), .filt_mode(filt_mode), .filt_beta(filt_beta),
        .filt_result(filt_result), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done),
        .err_mode(err_mode)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic pct(input int p);
        return ($urandom_range(0, 99) < 32'(p));
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_mode   = 2'b00;
        m_beta   = 8'h00;
        m_words  = 0;
        m_nin    = 0;
        m_nout   = 0;
        m_q.delete();
    endtask

    // Inputs are set by the caller at a falling edge; outputs are checked
    // shortly after, then the model advances across the next rising edge.
    task automatic step();
        logic exp_rdy, exp_ov, idle, in_x, out_x, last_out;
        #2;
        exp_ov  = (m_q.size() != 0);
        exp_rdy = m_active && !abort && (m_nin < m_words) && (!exp_ov || out_ready);
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_data", out_data, m_q[0]);
            chk("out_last", 32'(out_last), 32'(m_nout == m_words - 1));
        end else begin
            chk("out_last_idle", 32'(out_last), 32'd0);
        end
        chk("busy",      32'(busy),      32'(m_active));
        chk("done",      32'(done),      32'(m_done));
        chk("err_mode",  32'(err_mode),  32'(m_err));
        chk("filt_mode", 32'(filt_mode), 32'(m_mode));
        chk("filt_beta", 32'(filt_beta), 32'(m_beta));
        chk("filt_in",   filt_in,        in_data);

        if (rst) begin
            model_reset();
        end else if (abort) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_q.delete();
        end else begin
            idle     = !m_active && !m_done;
            in_x     = in_valid && exp_rdy;
            out_x    = exp_ov && out_ready;
            last_out = out_x && (m_nout == m_words - 1);
            m_done   = 1'b0;
            if (out_x) begin
                void'(m_q.pop_front());
                m_nout++;
            end
            if (in_x) begin
                m_q.push_back(in_data ^ {m_mode, 22'h0, m_beta});
                m_nin++;
            end
            if (last_out) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
            if (idle && start) begin
                m_mode  = cfg_mode;
                m_beta  = cfg_beta;
                m_words = int'(cfg_words);
                m_nin   = 0;
                m_nout  = 0;
                if (cfg_mode[1]) begin
                    m_err  = 1'b1;
                    m_done = 1'b1;
                end else begin
                    m_err = 1'b0;
                    if (cfg_words == '0) m_done = 1'b1;
                    else                 m_active = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    // kill_at >= 0 aborts (or resets) once that many words have been accepted.
    task automatic run_frame(input logic [1:0] mode, input logic [7:0] beta, input int words,
                             input int pv, input int pr, input int kill_at, input logic kill_rst);
        int          cyc;
        logic [31:0] r;
        cfg_mode  = mode;
        cfg_beta  = beta;
        cfg_words = words[CNT_W-1:0];
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = pct(pr);
        step();
        start = 1'b0;
        cyc   = 0;
        while ((m_active || m_done) && cyc < 400) begin
            r         = $urandom;
            in_valid  = pct(pv);
            in_data   = $urandom;
            out_ready = pct(pr);
            cfg_mode  = r[1:0];
            cfg_beta  = r[9:2];
            cfg_words = r[31:16];
            start     = m_active && pct(15);
            if (kill_at >= 0 && m_active && m_nin == kill_at) begin
                if (kill_rst) rst = 1'b1;
                else          abort = 1'b1;
            end
            step();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            cyc++;
        end
        chk("frame_timeout", 32'(m_active), 32'd0);
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();

        run_frame(2'b01, 8'd8, 4, 100, 100, -1, 1'b0);
        run_frame(2'b00, 8'd3, 3, 100, 20, -1, 1'b0);
        run_frame(2'b10, 8'd5, 4, 100, 100, -1, 1'b0);
        run_frame(2'b00, 8'd9, 2, 100, 100, -1, 1'b0);
        run_frame(2'b01, 8'd7, 6, 100, 100, 2, 1'b0);
        repeat (3) step();
        run_frame(2'b01, 8'd1, 2, 100, 100, -1, 1'b0);
        run_frame(2'b01, 8'd4, 0, 100, 100, -1, 1'b0);
        run_frame(2'b01, 8'hA5, 8, 80, 80, 3, 1'b1);
        run_frame(2'b11, 8'd2, 5, 100, 100, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            run_frame(r[1:0], r[9:2], int'($urandom_range(0, 10)),
                      int'($urandom_range(30, 100)), int'($urandom_range(25, 100)),
                      (r[12:10] == 3'd0) ? int'($urandom_range(0, 4)) : -1, r[13]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
